// File: rtl/pc_pkg.sv
// PC unit shared types.
// Next-PC mode encodings and control FSM state.
package pc_pkg;

   typedef enum logic [2:0] {
      MODE_SEQ    = 3'd0,
      MODE_JUMP   = 3'd1,
      MODE_BRANCH = 3'd2,
      MODE_JR     = 3'd3
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/pc_unit_if.sv
// PC unit control/target bundle.
// Master drives control, slave (pc_unit) returns PC state.
interface pc_unit_if #(
   parameter int ADDR_W = 32,
   parameter int OFFS_W = 26,
   parameter int IMM_W  = 16
);
   logic              stall;
   logic [2:0]        mode;
   logic              br_taken;
   logic              exc;
   logic [OFFS_W-1:0] offset;
   logic [IMM_W-1:0]  imm;
   logic [ADDR_W-1:0] rs_val;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] npc;
   logic              pending;
   logic              misalign;

   modport master (
      output stall, mode, br_taken, exc,
      output offset, imm, rs_val,
      input  pc, npc, pending, misalign
   );

   modport slave (
      input  stall, mode, br_taken, exc,
      input  offset, imm, rs_val,
      output pc, npc, pending, misalign
   );
endinterface

// File: rtl/pc_unit_jump_concat.sv
// J-type target formation.
// Upper bits of pc+4, then the word index, then 2'b00.
module jump_concat #(
   parameter int ADDR_W = 32,
   parameter int OFFS_W = 26
) (
   input  logic [ADDR_W-OFFS_W-3:0] seq_hi_i,
   input  logic [OFFS_W-1:0]        offset_i,
   output logic [ADDR_W-1:0]        target_o
);
   assign target_o = {seq_hi_i, offset_i, 2'b00};
endmodule

// File: rtl/pc_unit.sv
// Program counter with jump/branch/JR/exception redirect.
// A redirect seen under stall is parked until stall drops.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              OFFS_W   = 26,
   parameter int              IMM_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000,
   parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0040_0004
) (
   input  logic  clk,
   input  logic  rst,
   pc_unit_if.slave bus
);
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_q, pend_d;
   logic              mis_q, mis_d;
   state_e            state_q, state_d;

   logic [ADDR_W-1:0] seq, jmp_tgt, br_tgt, imm_ext;
   logic [ADDR_W-1:0] redir_tgt, npc;
   logic              redir;

   assign seq     = pc_q + ADDR_W'(4);
   assign imm_ext = {{(ADDR_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
   assign br_tgt  = seq + (imm_ext << 2);

   jump_concat #(
      .ADDR_W(ADDR_W),
      .OFFS_W(OFFS_W)
   ) u_jc (
      .seq_hi_i(seq[ADDR_W-1:OFFS_W+2]),
      .offset_i(bus.offset),
      .target_o(jmp_tgt)
   );

   // Redirect decode: exception beats any mode-driven redirect.
   always_comb begin
      redir     = 1'b0;
      redir_tgt = seq;
      mis_d     = 1'b0;
      case (bus.mode)
         MODE_JUMP: begin
            redir     = 1'b1;
            redir_tgt = jmp_tgt;
         end
         MODE_BRANCH: begin
            if (bus.br_taken) begin
               redir     = 1'b1;
               redir_tgt = br_tgt;
            end
         end
         MODE_JR: begin
            redir = 1'b1;
            if (bus.rs_val[1:0] != 2'b00) begin
               redir_tgt = EXC_VEC;
               mis_d     = 1'b1;
            end else begin
               redir_tgt = bus.rs_val;
            end
         end
         default: ;
      endcase
      if (bus.exc) begin
         redir     = 1'b1;
         redir_tgt = EXC_VEC;
         mis_d     = 1'b0;
      end
   end

   // Next-PC select: live redirect, then parked target, then pc+4.
   always_comb begin
      npc = seq;
      if (redir)
         npc = redir_tgt;
      else if (state_q == ST_HOLD)
         npc = pend_q;
   end

   // Control FSM next state, PC and parked-target updates.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      if (bus.stall) begin
         if (redir) begin
            pend_d  = redir_tgt;
            state_d = ST_HOLD;
         end
      end else begin
         pc_d    = npc;
         state_d = ST_RUN;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         mis_q   <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
         state_q <= state_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.npc      = npc;
   assign bus.pending  = (state_q == ST_HOLD);
   assign bus.misalign = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_pc_unit;
   import pc_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pc_unit_if bus ();

   pc_unit dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.stall    = 1'b0;
      bus.mode     = MODE_SEQ;
      bus.br_taken = 1'b0;
      bus.exc      = 1'b0;
      bus.offset   = '0;
      bus.imm      = '0;
      bus.rs_val   = '0;

      // reset values
      #12;
      chk("rst_pc", bus.pc, 32'h0040_0000);
      chk("rst_pend", {31'd0, bus.pending}, 32'd0);
      chk("rst_mis", {31'd0, bus.misalign}, 32'd0);
      rst = 1'b0;

      // sequential
      tick(); tick(); tick();
      chk("seq3", bus.pc, 32'h0040_000C);

      // wrap through JR
      bus.mode   = MODE_JR;
      bus.rs_val = 32'hFFFF_FFFC;
      tick();
      chk("jr_top", bus.pc, 32'hFFFF_FFFC);
      bus.mode = MODE_SEQ;
      #1;
      chk("wrap_npc", bus.npc, 32'h0000_0000);
      tick();
      chk("wrap_pc", bus.pc, 32'h0000_0000);

      // jump takes upper bits from seq
      bus.mode   = MODE_JR;
      bus.rs_val = 32'h0FFF_FFFC;
      tick();
      bus.mode   = MODE_JUMP;
      bus.offset = 26'h000_0010;
      #1;
      chk("jump_npc", bus.npc, 32'h1000_0040);
      tick();
      chk("jump_pc", bus.pc, 32'h1000_0040);

      // branch taken / not taken
      bus.mode   = MODE_JR;
      bus.rs_val = 32'h0040_0010;
      tick();
      bus.mode     = MODE_BRANCH;
      bus.br_taken = 1'b1;
      bus.imm      = 16'hFFFE;
      #1;
      chk("br_taken", bus.npc, 32'h0040_000C);
      bus.br_taken = 1'b0;
      #1;
      chk("br_not", bus.npc, 32'h0040_0014);
      bus.mode = 3'd6;
      bus.br_taken = 1'b1;
      #1;
      chk("rsvd_mode", bus.npc, 32'h0040_0014);
      bus.mode = MODE_SEQ;
      bus.br_taken = 1'b0;
      tick();
      chk("br_pc", bus.pc, 32'h0040_0014);

      // stall capture of a jump (seq=0x00400018 -> target 0x80)
      bus.stall  = 1'b1;
      bus.mode   = MODE_JUMP;
      bus.offset = 26'h000_0020;
      tick();
      chk("cap_pend", {31'd0, bus.pending}, 32'd1);
      chk("cap_pc", bus.pc, 32'h0040_0014);
      bus.mode = MODE_SEQ;
      tick();
      tick();
      chk("hold_pend", {31'd0, bus.pending}, 32'd1);
      chk("hold_pc", bus.pc, 32'h0040_0014);
      chk("hold_npc", bus.npc, 32'h0000_0080);
      bus.stall = 1'b0;
      tick();
      chk("rel_pc", bus.pc, 32'h0000_0080);
      chk("rel_pend", {31'd0, bus.pending}, 32'd0);

      // exception beats JR
      bus.exc    = 1'b1;
      bus.mode   = MODE_JR;
      bus.rs_val = 32'h1234_5678;
      #1;
      chk("exc_npc", bus.npc, 32'h0040_0004);
      tick();
      chk("exc_pc", bus.pc, 32'h0040_0004);

      // misaligned JR
      bus.exc    = 1'b0;
      bus.rs_val = 32'h0040_0002;
      tick();
      chk("mis_pc", bus.pc, 32'h0040_0004);
      chk("mis_pulse", {31'd0, bus.misalign}, 32'd1);
      bus.mode = MODE_SEQ;
      tick();
      chk("mis_clear", {31'd0, bus.misalign}, 32'd0);
      chk("mis_next", bus.pc, 32'h0040_0008);

      // misaligned JR captured under stall pulses once
      bus.stall = 1'b1;
      bus.mode  = MODE_JR;
      tick();
      chk("smis_pulse", {31'd0, bus.misalign}, 32'd1);
      bus.mode = MODE_SEQ;
      tick();
      chk("smis_once", {31'd0, bus.misalign}, 32'd0);
      bus.stall = 1'b0;
      tick();
      chk("smis_pc", bus.pc, 32'h0040_0004);

      // reset while holding discards the parked target
      bus.stall = 1'b1;
      bus.mode  = MODE_JUMP;
      tick();
      chk("rh_pend", {31'd0, bus.pending}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rh_pc", bus.pc, 32'h0040_0000);
      chk("rh_pend0", {31'd0, bus.pending}, 32'd0);
      bus.stall = 1'b0;
      bus.mode  = MODE_SEQ;
      #6;
      rst = 1'b0;
      tick();
      chk("rh_after", bus.pc, 32'h0040_0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, sets the PC and target width; legal only when ADDR_W >= OFFS_W+3.
REQ-002 Parameter OFFS_W, default 26, sets the J-type index width.
REQ-003 Parameter IMM_W, default 16, sets the branch immediate width.
REQ-004 Parameter RESET_PC, default 32'h0040_0000, sets the PC value loaded on reset.
REQ-005 Parameter EXC_VEC, default 32'h0040_0004, sets the exception/misalign redirect target.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port stall, input, 1 bit: when 1, the PC holds its value.
REQ-009 Port mode, input, 3 bits: next-PC mode (SEQ, JUMP, BRANCH, JR).
REQ-010 Port br_taken, input, 1 bit: qualifies BRANCH mode.
REQ-011 Port exc, input, 1 bit: exception request.
REQ-012 Port offset, input, OFFS_W bits: J-type index.
REQ-013 Port imm, input, IMM_W bits: signed branch word offset.
REQ-014 Port rs_val, input, ADDR_W bits: JR target.
REQ-015 Port pc, output, ADDR_W bits: current registered PC.
REQ-016 Port npc, output, ADDR_W bits: combinational next PC.
REQ-017 Port pending, output, 1 bit: a redirect is captured and awaiting the release of stall.
REQ-018 Port misalign, output, 1 bit: registered one-cycle pulse flagging a misaligned JR.

Function
REQ-019 The unit computes seq as pc+4, modulo 2^ADDR_W.
REQ-020 The jump target is {seq[ADDR_W-1:OFFS_W+2], offset, 2'b00}, using the upper bits of seq, not of pc.
REQ-021 The branch target is seq + (sign-extended imm << 2), wrapping modulo 2^ADDR_W.
REQ-022 The JR target is rs_val; if rs_val[1:0] != 0 the redirect target becomes EXC_VEC and misalign pulses the following cycle.
REQ-023 A redirect is any of: exc=1, mode=JUMP, mode=JR, or mode=BRANCH with br_taken=1.
REQ-024 Target selection priority, highest first:
- exc, giving EXC_VEC;
- the mode redirect;
- the pending target;
- seq.
REQ-025 A mode=BRANCH with br_taken=0 selects seq.
REQ-026 Reserved mode encodings select seq.
REQ-027 npc always shows the selected target for the current cycle, with zero latency.
REQ-028 The control FSM has two states, RUN and HOLD.
REQ-029 In RUN with stall=0: pc <= npc.
REQ-030 In RUN with stall=1 and no redirect: pc holds.
REQ-031 In RUN with stall=1 and a redirect: pc holds, the target is captured in a pending register, and the FSM goes to HOLD.
REQ-032 In HOLD with stall=1: pc holds; a new redirect overwrites the pending target (latest wins).
REQ-033 In HOLD with stall=0: pc <= npc, the new redirect if one is present, otherwise the pending target; the FSM goes to RUN.
REQ-034 pending equals (state == HOLD).
REQ-035 A misaligned JR captured while stalled still pulses misalign exactly once, in the cycle after capture.
REQ-036 All arithmetic is unsigned ADDR_W bits; carries out of the MSB are discarded.

Reset
REQ-037 While rst=1, asynchronously: pc = RESET_PC, state = RUN, the pending target = 0, and misalign = 0.
REQ-038 The first rising edge after rst deasserts applies the normal update rules.
REQ-039 Reset asserted mid-HOLD discards the captured target.

Structure
REQ-040 Package pc_pkg holds the mode encodings (SEQ=0, JUMP=1, BRANCH=2, JR=3) and the FSM state type.
REQ-041 Sub-module jump_concat, parametrised by ADDR_W and OFFS_W, forms the jump target combinationally; all other logic is in pc_unit.

Verification
REQ-042 Sequential wrap: after reset, pc=32'h0040_0000; 3 cycles of SEQ give 32'h0040_000C; pc forced to 32'hFFFF_FFFC via JR wraps to 32'h0000_0000 on the next SEQ.
REQ-043 Jump: pc=32'h0FFF_FFFC, JUMP, offset=26'h0000010 gives npc=32'h1000_0040 (upper bits taken from seq).
REQ-044 Branch: pc=32'h0040_0010, BRANCH, br_taken=1, imm=16'hFFFE gives npc=32'h0040_000C; with br_taken=0 it gives 32'h0040_0014.
REQ-045 Stall capture: stall=1 with JUMP, then 2 stalled cycles with SEQ: pending=1 and pc holds; when stall drops, pc equals the captured jump target and pending=0.
REQ-046 Priority: exc=1 together with mode=JR and rs_val=32'h1234_5678 gives pc=EXC_VEC; JR with rs_val=32'h0040_0002 gives pc=EXC_VEC and one misalign pulse.
REQ-047 Reset in HOLD: rst asserted while pending=1 gives pc=RESET_PC and pending=0 immediately, before any clock edge.
